fetch_sequencer: RTL and testbench

- Front-end controller that sequences instruction fetch for the core.
- Owns the fetch PC and drives the single-outstanding instruction-memory request handshake.
- Buffers fetched {pc, instr} pairs in a small FIFO toward dispatch.
- Handles redirects (flush/misprediction), including squashing an in-flight imem response.
- Sits between imem/I-cache and dispatch; consumes the fetch_if signals (flush, stall, dispatch_free, pc_prediction, misprediction, correct_target, imemload) and produces instr/pc.

---
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch front-end: owns the fetch PC, drives a single-outstanding imem request and
// buffers {pc, instr} pairs in a small queue toward dispatch.
module fetch_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            nRST,
    output logic            imem_ren,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ihit,
    input  logic [XLEN-1:0] imemload,
    input  logic [XLEN-1:0] pc_prediction,
    input  logic            pred_taken,
    input  logic            flush,
    input  logic            misprediction,
    input  logic [XLEN-1:0] correct_target,
    input  logic            stall,
    input  logic            dispatch_free,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {StRun, StSquash} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   squash_addr_q, squash_addr_d;
    logic              req_active_q, req_active_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;

    logic [XLEN-1:0]   pc_mem [QDEPTH];
    logic [XLEN-1:0]   instr_mem [QDEPTH];

    logic redirect;
    logic accept;
    logic push;
    logic pop;

    assign redirect = flush | misprediction;

    // Request side; nRST gating keeps ren low while reset is held.
    always_comb begin
        imem_ren  = 1'b0;
        imem_addr = fetch_pc_q;
        if (state_q == StSquash) begin
            imem_ren  = nRST;
            imem_addr = squash_addr_q;
        end else begin
            imem_ren = nRST & (req_active_q | (count_q < CntW'(QDEPTH)));
        end
    end

    assign accept      = imem_ren & imem_ihit;
    assign push        = (state_q == StRun) & accept & ~redirect;
    assign instr_valid = (count_q != '0) & ~redirect;
    assign pop         = instr_valid & dispatch_free & ~stall;
    assign instr       = (count_q != '0) ? instr_mem[head_q] : '0;
    assign pc          = (count_q != '0) ? pc_mem[head_q] : '0;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        squash_addr_d = squash_addr_q;
        req_active_d  = accept ? 1'b0 : (imem_ren | req_active_q);

        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    // A request still in flight must complete at its original address.
                    if (imem_ren && !imem_ihit) begin
                        squash_addr_d = fetch_pc_q;
                        state_d       = StSquash;
                    end
                    fetch_pc_d = correct_target;
                end else if (push) begin
                    fetch_pc_d = pred_taken ? pc_prediction : fetch_pc_q + XLEN'(4);
                end
            end
            StSquash: begin
                if (redirect) begin
                    fetch_pc_d = correct_target;
                end
                if (accept) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PtrW'(1);
            if (pop)  head_d = head_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            squash_addr_q <= '0;
            req_active_q  <= 1'b0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            squash_addr_q <= squash_addr_d;
            req_active_q  <= req_active_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            instr_mem[tail_q] <= imemload;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, back-pressure, prediction,
// squash of an in-flight response, flush with push/pop, and mid-request reset.
module tb_fetch_sequencer;

    localparam logic [31:0] MAGIC = 32'hC0DE_0000;

    logic        CLK;
    logic        nRST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_ihit;
    logic [31:0] imemload;
    logic [31:0] pc_prediction;
    logic        pred_taken;
    logic        flush;
    logic        misprediction;
    logic [31:0] correct_target;
    logic        stall;
    logic        dispatch_free;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;

    int errors;
    int checks;

    fetch_sequencer #(
        .XLEN     (32),
        .QDEPTH   (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .imem_ren       (imem_ren),
        .imem_addr      (imem_addr),
        .imem_ihit      (imem_ihit),
        .imemload       (imemload),
        .pc_prediction  (pc_prediction),
        .pred_taken     (pred_taken),
        .flush          (flush),
        .misprediction  (misprediction),
        .correct_target (correct_target),
        .stall          (stall),
        .dispatch_free  (dispatch_free),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc)
    );

    // Memory model: each word is its address tagged with a constant.
    assign imemload = imem_addr ^ MAGIC;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST           = 1'b0;
        imem_ihit      = 1'b0;
        flush          = 1'b0;
        misprediction  = 1'b0;
        stall          = 1'b0;
        dispatch_free  = 1'b1;
        pred_taken     = 1'b0;
        pc_prediction  = '0;
        correct_target = '0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST = 1'b1;
        imem_ihit = 1'b0; flush = 1'b0; misprediction = 1'b0; stall = 1'b0;
        dispatch_free = 1'b1; pred_taken = 1'b0; pc_prediction = '0; correct_target = '0;

        // Reset state
        #3 nRST = 1'b0;
        imem_ihit = 1'b1;
        #1;
        check("rst_ren", 32'(imem_ren), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);

        // Streaming with ihit every cycle
        do_reset();
        imem_ihit = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("str_ren", 32'(imem_ren), 32'd1);
            check("str_addr", imem_addr, 32'(4 * k));
            if (k == 0) begin
                check("str_valid0", 32'(instr_valid), 32'd0);
            end else begin
                check("str_valid", 32'(instr_valid), 32'd1);
                check("str_pc", pc, 32'(4 * (k - 1)));
                check("str_instr", instr, 32'(4 * (k - 1)) ^ MAGIC);
            end
            tick();
        end

        // Stall fills the queue, then drains in order
        do_reset();
        stall = 1'b1;
        imem_ihit = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("full_ren", 32'(imem_ren), 32'd0);
            check("full_valid", 32'(instr_valid), 32'd1);
            check("full_pc", pc, 32'd0);
            tick();
        end
        stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("drain_valid", 32'(instr_valid), 32'd1);
            check("drain_pc", pc, 32'(4 * i));
            check("drain_instr", instr, 32'(4 * i) ^ MAGIC);
            if (i == 0) begin
                check("drain_ren0", 32'(imem_ren), 32'd0);
            end else begin
                check("drain_ren", 32'(imem_ren), 32'd1);
                check("drain_addr", imem_addr, 32'(16 + 4 * (i - 1)));
            end
            tick();
        end

        // Predicted-taken redirect of the fetch stream
        do_reset();
        imem_ihit = 1'b1;
        pc_prediction = 32'h100;
        for (int c = 1; c <= 5; c++) begin
            pred_taken = (c == 3);
            #1;
            check("pred_addr", imem_addr,
                  (c <= 3) ? 32'(4 * (c - 1)) : 32'h100 + 32'(4 * (c - 4)));
            if (c >= 2) begin
                check("pred_pc", pc, (c <= 4) ? 32'(4 * (c - 2)) : 32'h100);
            end
            tick();
        end
        pred_taken = 1'b0;

        // Misprediction while a response is outstanding
        do_reset();
        #1;
        check("sq_addr_c1", imem_addr, 32'h0);
        tick();
        misprediction = 1'b1;
        correct_target = 32'h200;
        #1;
        check("sq_addr_c2", imem_addr, 32'h0);
        check("sq_ren_c2", 32'(imem_ren), 32'd1);
        tick();
        misprediction = 1'b0;
        #1;
        check("sq_addr_c3", imem_addr, 32'h0);
        check("sq_ren_c3", 32'(imem_ren), 32'd1);
        tick();
        imem_ihit = 1'b1;
        #1;
        check("sq_addr_c4", imem_addr, 32'h0);
        tick();
        imem_ihit = 1'b0;
        #1;
        check("sq_addr_new", imem_addr, 32'h200);
        check("sq_ren_new", 32'(imem_ren), 32'd1);
        check("sq_valid_new", 32'(instr_valid), 32'd0);
        tick();
        imem_ihit = 1'b1;
        tick();
        imem_ihit = 1'b0;
        #1;
        check("sq_valid", 32'(instr_valid), 32'd1);
        check("sq_pc", pc, 32'h200);
        check("sq_instr", instr, 32'h200 ^ MAGIC);

        // Flush coinciding with ihit and a pop, two entries queued
        do_reset();
        imem_ihit = 1'b1;
        dispatch_free = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        correct_target = 32'h300;
        dispatch_free = 1'b1;
        #1;
        check("fl_valid", 32'(instr_valid), 32'd0);
        check("fl_addr", imem_addr, 32'h8);
        tick();
        flush = 1'b0;
        imem_ihit = 1'b0;
        #1;
        check("fl_valid_after", 32'(instr_valid), 32'd0);
        check("fl_pc_after", pc, 32'd0);
        check("fl_instr_after", instr, 32'd0);
        check("fl_addr_after", imem_addr, 32'h300);
        check("fl_ren_after", 32'(imem_ren), 32'd1);
        imem_ihit = 1'b1;
        tick();
        imem_ihit = 1'b0;
        #1;
        check("fl_new_valid", 32'(instr_valid), 32'd1);
        check("fl_new_pc", pc, 32'h300);

        // Reset mid-request with three entries queued
        do_reset();
        imem_ihit = 1'b1;
        dispatch_free = 1'b0;
        repeat (3) tick();
        imem_ihit = 1'b0;
        #1;
        check("mr_ren_pre", 32'(imem_ren), 32'd1);
        check("mr_addr_pre", imem_addr, 32'hC);
        check("mr_valid_pre", 32'(instr_valid), 32'd1);
        nRST = 1'b0;
        #1;
        check("mr_ren", 32'(imem_ren), 32'd0);
        check("mr_valid", 32'(instr_valid), 32'd0);
        check("mr_pc", pc, 32'd0);
        check("mr_instr", instr, 32'd0);
        imem_ihit = 1'b1;
        tick();
        tick();
        imem_ihit = 1'b0;
        dispatch_free = 1'b1;
        nRST = 1'b1;
        #1;
        check("mr_restart_addr", imem_addr, 32'h0);
        check("mr_restart_ren", 32'(imem_ren), 32'd1);
        check("mr_restart_valid", 32'(instr_valid), 32'd0);
        imem_ihit = 1'b1;
        tick();
        imem_ihit = 1'b0;
        #1;
        check("mr_first_valid", 32'(instr_valid), 32'd1);
        check("mr_first_pc", pc, 32'h0);
        check("mr_next_addr", imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
